fsm_state_checker: RTL and testbench
====================================

// Module: fsm_state_checker
// PURPOSE
//  Receiving end of the FSM's 1-bit state_out stream. Samples it every clk and detects a
//  programmable bit pattern, overlaps included. Counts matches and tracks run length.
//  Flags a stuck output: more than MAX_RUN identical consecutive samples.
//  Sits beside the FSM in the design and its bench as a synthesizable self-check.
// PARAMETERS
//  PATTERN_W  4        pattern length in bits (2..16)
//  PATTERN    4'b1011  pattern; MSB is the oldest sample
//  MAX_RUN    16       longest legal run of identical samples (>=2)
//  CNT_W      16       width of match_count
//  RUN_W      $clog2(MAX_RUN+2)  width of run_len (derived, localparam)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  enable       in   1       1 = sample state_in every clk
//  state_in     in   1       FSM state_out bit
//  clear_err    in   1       1-cycle pulse: clears stuck_err, restarts priming
//  match        out  1       1-cycle pulse on a pattern hit
//  match_count  out  CNT_W   total hits, saturating
//  run_len      out  RUN_W   consecutive identical samples incl. latest, saturating
//  stuck_err    out  1       sticky stuck-output flag
//  primed       out  1       PATTERN_W valid samples held since last (re)start
// BEHAVIOUR
//  - All outputs are registered. Reset (sync) forces state=IDLE, shift reg=0, sample fill count=0, and
//    match=0, match_count=0, run_len=0, stuck_err=0, primed=0. Reset wins over all other inputs.
//  - FSM states: IDLE, PRIME, TRACK, FAULT.
//    IDLE : enable=1 -> PRIME; the same edge takes the first sample.
//    PRIME: sample each clk; after PATTERN_W samples -> TRACK, primed=1.
//    TRACK: sample each clk; a run overflow -> FAULT.
//    FAULT: stuck_err=1, no match pulses, run_len keeps counting.
//           clear_err=1 -> PRIME: shift reg, fill count and run_len cleared.
//           match_count is kept.
//    enable=0 in PRIME/TRACK -> IDLE: primed=0, history discarded, counters held.
//    enable=0 in FAULT stays FAULT.
//  - Sample at edge N: shift reg becomes {sr[PATTERN_W-2:0], state_in}.
//  - Match check: at edge N, if the new shift reg equals PATTERN and the state is
//    TRACK, or PRIME with this being the PATTERN_W-th sample, then match=1 for
//    exactly the cycle following edge N. Latency is 0 cycles after the sampling edge.
//    Overlap example: 1011011 gives 2 hits.
//  - match_count increments on each hit and holds at 2^CNT_W-1; no wrap.
//  - run_len: first sample after (re)start -> 1.
//    Sample equal to the previous one -> +1, saturating at MAX_RUN+1. Different -> 1.
//  - Overflow: the edge where run_len becomes MAX_RUN+1 sets stuck_err=1 and enters
//    FAULT. A hit completing on that same edge still pulses match and counts.
//  - Simultaneous clear_err and overflow in FAULT: clear wins, run_len restarts at 1.
//    clear_err outside FAULT is ignored.
//  - Reset mid-stream: next cycle is indistinguishable from power-up.
// STRUCTURE
//  - Package fsm_check_pkg:
//    typedef enum logic [1:0] {IDLE, PRIME, TRACK, FAULT} chk_state_t
//    localparam DEFAULT_PATTERN = 4'b1011
//    localparam DEFAULT_MAX_RUN = 16
//  - Sub-module run_length_counter (params MAX_RUN, RUN_W):
//    inputs clk, reset, restart, sample_en, bit_in
//    outputs run_len, overflow
//  - Top holds the FSM, shift reg, fill counter and match logic.
// TESTING
//  1 reset high 2 clks, enable=1, state_in=1,0,1,1,0,1,1
//    -> match high after 4th and 7th edges only; match_count=2; primed=1 after 4th.
//  2 pattern 1011 during PRIME, then enable=0 for 1 clk, then stream 0,1,1
//    -> no match; primed=0 then back to PRIME; match_count unchanged.
//  3 state_in held 1 for 16 samples -> run_len=16, stuck_err=0.
//    17th sample -> run_len=17, stuck_err=1, FAULT.
//  4 in FAULT, drive 1011 -> no match; clear_err=1
//    -> stuck_err=0, primed=0; next 1011 -> match=1, count+1.
//  5 CNT_W=3, send 9 overlapping hits (1011011011...)
//    -> match_count stops at 7; match still pulses.
//  6 assert reset mid-match on the edge completing 1011
//    -> match=0, match_count=0, run_len=0, state IDLE next cycle.

Source files
------------

// File: rtl/fsm_check_pkg.sv
// Shared types and defaults for the state_out stream checker.
package fsm_check_pkg;

  typedef enum logic [1:0] {IDLE, PRIME, TRACK, FAULT} chk_state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;
  localparam int         DEFAULT_MAX_RUN = 16;

endpackage

// File: rtl/run_length_counter.sv
// Counts consecutive identical samples, saturating one past the legal maximum.
module run_length_counter #(
  parameter int MAX_RUN = 16,
  parameter int RUN_W   = $clog2(MAX_RUN + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             sample_en,
  input  logic             bit_in,
  output logic [RUN_W-1:0] run_len,
  output logic             overflow
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic last_bit;
  logic same;

  // A zero run_len means no history yet, so the next sample starts a fresh run.
  assign same     = (bit_in == last_bit) && (run_len != '0);
  assign overflow = sample_en && !restart && same && (run_len == RUN_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      run_len  <= '0;
      last_bit <= 1'b0;
    end else if (restart) begin
      run_len  <= sample_en ? RUN_ONE : '0;
      last_bit <= sample_en ? bit_in : 1'b0;
    end else if (sample_en) begin
      last_bit <= bit_in;
      if (!same)
        run_len <= RUN_ONE;
      else if (run_len != RUN_SAT)
        run_len <= run_len + RUN_ONE;
    end
  end

endmodule

// File: rtl/fsm_state_checker.sv
// Monitors the FSM state_out bit stream: pattern hits, hit count, run length
// and a sticky stuck-output flag.
module fsm_state_checker
  import fsm_check_pkg::*;
#(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEFAULT_PATTERN),
  parameter int                   MAX_RUN   = DEFAULT_MAX_RUN,
  parameter int                   CNT_W     = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            state_in,
  input  logic                            clear_err,
  output logic                            match,
  output logic [CNT_W-1:0]                match_count,
  output logic [$clog2(MAX_RUN+2)-1:0]    run_len,
  output logic                            stuck_err,
  output logic                            primed
);

  localparam int                RUN_W     = $clog2(MAX_RUN + 2);
  localparam int                FILL_W    = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(PATTERN_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  chk_state_t           state;
  logic [PATTERN_W-1:0] sr;
  logic [PATTERN_W-1:0] sr_shift;
  logic [PATTERN_W-1:0] sr_first;
  logic [FILL_W-1:0]    fill;
  logic                 hit;
  logic                 restart;
  logic                 overflow;

  assign sr_shift = {sr[PATTERN_W-2:0], state_in};
  assign sr_first = {{(PATTERN_W-1){1'b0}}, state_in};
  assign hit      = (sr_shift == PATTERN);
  assign restart  = ((state == IDLE) && enable) || ((state == FAULT) && clear_err);

  run_length_counter #(
    .MAX_RUN (MAX_RUN),
    .RUN_W   (RUN_W)
  ) u_run (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .sample_en (enable),
    .bit_in    (state_in),
    .run_len   (run_len),
    .overflow  (overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sr          <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
      stuck_err   <= 1'b0;
      primed      <= 1'b0;
    end else begin
      match <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= PRIME;
            sr    <= sr_first;
            fill  <= FILL_ONE;
          end
        end
        PRIME, TRACK: begin
          if (!enable) begin
            state  <= IDLE;
            sr     <= '0;
            fill   <= '0;
            primed <= 1'b0;
          end else begin
            sr <= sr_shift;
            if (state == PRIME)
              fill <= fill + FILL_ONE;
            if ((state == TRACK) || (fill == LAST_FILL)) begin
              match <= hit;
              if (hit && (match_count != CNT_MAX))
                match_count <= match_count + CNT_ONE;
              primed <= 1'b1;
              state  <= TRACK;
            end
            // A hit completing on the overflow edge still counts above.
            if (overflow) begin
              state     <= FAULT;
              stuck_err <= 1'b1;
            end
          end
        end
        FAULT: begin
          if (clear_err) begin
            state     <= PRIME;
            stuck_err <= 1'b0;
            primed    <= 1'b0;
            sr        <= enable ? sr_first : '0;
            fill      <= enable ? FILL_ONE : '0;
          end else if (enable) begin
            sr <= sr_shift;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_state_checker.sv
// Directed bench for fsm_state_checker: default instance plus a 3-bit counter instance.
module tb_fsm_state_checker;

  logic        clk = 1'b0;
  logic        reset, enable, state_in, clear_err;
  logic        match1, stuck1, primed1;
  logic [15:0] cnt1;
  logic [4:0]  run1;

  logic        r2, en2, in2, clr2;
  logic        match2, stuck2, primed2;
  logic [2:0]  cnt2;
  logic [4:0]  run2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsm_state_checker dut (
    .clk (clk), .reset (reset), .enable (enable), .state_in (state_in),
    .clear_err (clear_err), .match (match1), .match_count (cnt1),
    .run_len (run1), .stuck_err (stuck1), .primed (primed1)
  );

  fsm_state_checker #(.CNT_W(3)) dut_sat (
    .clk (clk), .reset (r2), .enable (en2), .state_in (in2),
    .clear_err (clr2), .match (match2), .match_count (cnt2),
    .run_len (run2), .stuck_err (stuck2), .primed (primed2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic d, input logic clr);
    enable = en; state_in = d; clear_err = clr;
    @(posedge clk); #1;
  endtask

  task automatic step2(input logic en, input logic d);
    en2 = en; in2 = d; clr2 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic t1_in [7];
    logic t1_m  [7];
    logic seq4  [5];
    int   hits;
    logic d;
    logic em;

    t1_in = '{1, 0, 1, 1, 0, 1, 1};
    t1_m  = '{0, 0, 0, 1, 0, 0, 1};
    seq4  = '{0, 1, 0, 1, 1};

    reset = 1'b1; enable = 1'b0; state_in = 1'b0; clear_err = 1'b0;
    r2 = 1'b1; en2 = 1'b0; in2 = 1'b0; clr2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_match",  32'(match1), 0);
    chk("rst_count",  32'(cnt1),   0);
    chk("rst_run",    32'(run1),   0);
    chk("rst_stuck",  32'(stuck1), 0);
    chk("rst_primed", 32'(primed1), 0);
    chk("rst_count2", 32'(cnt2),   0);
    reset = 1'b0;

    // Overlapping hits on 1011011
    for (int i = 0; i < 7; i++) begin
      step(1'b1, t1_in[i], 1'b0);
      chk("t1_match",  32'(match1),  32'(t1_m[i]));
      chk("t1_primed", 32'(primed1), (i >= 3) ? 1 : 0);
    end
    chk("t1_count", 32'(cnt1), 2);

    // Disable discards priming history
    step(1'b0, 1'b1, 1'b0);
    chk("t2_primed_off", 32'(primed1), 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i == 1) ? 1'b0 : 1'b1, 1'b0);
      chk("t2_match_a", 32'(match1), 0);
    end
    step(1'b0, 1'b1, 1'b0);
    chk("t2_primed_idle", 32'(primed1), 0);
    chk("t2_run_held",    32'(run1),    1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i == 0) ? 1'b0 : 1'b1, 1'b0);
      chk("t2_match_b", 32'(match1), 0);
    end
    chk("t2_primed", 32'(primed1), 0);
    chk("t2_count",  32'(cnt1),    2);
    chk("t2_run",    32'(run1),    2);
    step(1'b1, 1'b0, 1'b0);
    chk("t2_primed_on", 32'(primed1), 1);
    chk("t2_run_new",   32'(run1),    1);

    // Run of ones up to and past MAX_RUN
    for (int j = 0; j < 16; j++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("t3_match", 32'(match1), (j == 1) ? 1 : 0);
    end
    chk("t3_run16",   32'(run1),   16);
    chk("t3_stuck16", 32'(stuck1), 0);
    chk("t3_count",   32'(cnt1),   3);
    step(1'b1, 1'b1, 1'b0);
    chk("t3_run17",   32'(run1),   17);
    chk("t3_stuck17", 32'(stuck1), 1);
    step(1'b1, 1'b1, 1'b0);
    chk("t3_run_sat", 32'(run1),   17);
    chk("t3_sticky",  32'(stuck1), 1);

    // FAULT suppresses matches; clear_err restarts priming
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq4[i], 1'b0);
      chk("t4_nomatch", 32'(match1), 0);
    end
    chk("t4_count_f", 32'(cnt1),   3);
    chk("t4_run_f",   32'(run1),   2);
    chk("t4_stuck_f", 32'(stuck1), 1);
    step(1'b1, 1'b1, 1'b1);
    chk("t4_clr_stuck",  32'(stuck1),  0);
    chk("t4_clr_primed", 32'(primed1), 0);
    chk("t4_clr_run",    32'(run1),    1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i == 0) ? 1'b0 : 1'b1, 1'b0);
      chk("t4_match", 32'(match1), (i == 2) ? 1 : 0);
    end
    chk("t4_count",  32'(cnt1),    4);
    chk("t4_primed", 32'(primed1), 1);
    step(1'b1, 1'b0, 1'b1);
    chk("t4_clr_ignored", 32'(primed1), 1);
    chk("t4_clr_nostuck", 32'(stuck1),  0);

    // Reset on the edge completing 1011
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    chk("t6_match",  32'(match1),  0);
    chk("t6_count",  32'(cnt1),    0);
    chk("t6_run",    32'(run1),    0);
    chk("t6_primed", 32'(primed1), 0);
    chk("t6_stuck",  32'(stuck1),  0);
    step(1'b0, 1'b0, 1'b0);
    chk("t6_idle_run", 32'(run1), 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 1) ? 1'b0 : 1'b1, 1'b0);
      chk("t6_rematch", 32'(match1), (i == 3) ? 1 : 0);
    end
    chk("t6_recount", 32'(cnt1), 1);

    // Saturating 3-bit counter over 9 overlapping hits
    r2 = 1'b0;
    hits = 0;
    for (int i = 0; i < 28; i++) begin
      d  = (i == 0) ? 1'b1 : ((i % 3 == 1) ? 1'b0 : 1'b1);
      em = (i >= 3) && (i % 3 == 0);
      if (em) hits++;
      step2(1'b1, d);
      chk("t5_match", 32'(match2), 32'(em));
      chk("t5_count", 32'(cnt2),   (hits > 7) ? 7 : hits);
    end
    chk("t5_final", 32'(cnt2), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
